// File: rtl/sr_write_verify_ctrl_if.sv
// sr_write_verify_ctrl_if: command handshake between a requester and the write-verify sequencer
//   cmd_valid  requester -> sequencer  command request
//   cmd_ready  sequencer -> requester  sequencer idle and able to accept
//   cmd_data   requester -> sequencer  configuration word to load
//   max_retry  requester -> sequencer  extra verify passes allowed after the first
interface sr_write_verify_ctrl_if #(
    parameter int WIDTH       = 170,
    parameter int RETRY_WIDTH = 2
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [WIDTH-1:0]       cmd_data;
    logic [RETRY_WIDTH-1:0] max_retry;
    modport master (output cmd_valid, cmd_data, max_retry, input cmd_ready);
    modport slave  (input cmd_valid, cmd_data, max_retry, output cmd_ready);
endinterface

// File: rtl/sr_write_verify_ctrl.sv
// sr_write_verify_ctrl: shifts a configuration word into the shift-register datapath twice and verifies the read-back
//   clk           divided datapath control clock
//   rst           asynchronous active-low reset
//   cmd           command handshake (slave side)
//   sr_start      one-cycle start pulse to the datapath
//   sr_din        word to the datapath, held from accept to done
//   sr_valid      datapath read-back valid pulse
//   sr_dout       datapath read-back word
//   prev_data     register contents before this command (pass-1 read-back)
//   done          one-cycle completion pulse
//   ok            last command verified
//   err_mismatch  retries exhausted with mismatch
//   err_timeout   per-pass watchdog expired
//   retries       retry passes used by last command
//   busy          not idle
module sr_write_verify_ctrl #(
    parameter int WIDTH         = 170,
    parameter int RETRY_WIDTH   = 2,
    parameter int TIMEOUT_WIDTH = 12,
    parameter int GAP_CYCLES    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    sr_write_verify_ctrl_if.slave  cmd,
    output logic                   sr_start,
    output logic [WIDTH-1:0]       sr_din,
    input  logic                   sr_valid,
    input  logic [WIDTH-1:0]       sr_dout,
    output logic [WIDTH-1:0]       prev_data,
    output logic                   done,
    output logic                   ok,
    output logic                   err_mismatch,
    output logic                   err_timeout,
    output logic [RETRY_WIDTH-1:0] retries,
    output logic                   busy
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START1 = 3'd1;
    localparam logic [2:0] WAIT1  = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] START2 = 3'd4;
    localparam logic [2:0] WAIT2  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    // The watchdog reaches its terminal count 2**TIMEOUT_WIDTH-1 on the edge
    // leaving the cycle in which it holds one less, so that cycle ends the pass.
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = ~TIMEOUT_WIDTH'(1);

    logic [2:0]               state;
    logic [RETRY_WIDTH-1:0]   limit;
    logic [TIMEOUT_WIDTH-1:0] wd;
    logic [GW-1:0]            gap_cnt;

    assign cmd.cmd_ready = state == IDLE;
    assign busy          = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            limit        <= '0;
            wd           <= '0;
            gap_cnt      <= '0;
            sr_start     <= 1'b0;
            sr_din       <= '0;
            prev_data    <= '0;
            done         <= 1'b0;
            ok           <= 1'b0;
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
            retries      <= '0;
        end else begin
            sr_start <= 1'b0;
            done     <= 1'b0;
            wd       <= wd + 1'b1;
            gap_cnt  <= gap_cnt + 1'b1;
            case (state)
                IDLE: if (cmd.cmd_valid) begin
                    sr_din       <= cmd.cmd_data;
                    limit        <= cmd.max_retry;
                    retries      <= '0;
                    ok           <= 1'b0;
                    err_mismatch <= 1'b0;
                    err_timeout  <= 1'b0;
                    sr_start     <= 1'b1;
                    state        <= START1;
                end
                START1, START2: begin
                    wd    <= '0;
                    state <= state == START1 ? WAIT1 : WAIT2;
                end
                // A read-back arriving on the terminal-count cycle takes priority over the timeout.
                WAIT1, WAIT2: if (sr_valid) begin
                    if (state == WAIT1) begin
                        prev_data <= sr_dout;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end else if (sr_dout == sr_din) begin
                        ok    <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (retries != limit) begin
                        retries <= retries + 1'b1;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        err_mismatch <= 1'b1;
                        done         <= 1'b1;
                        state        <= DONE;
                    end
                end else if (wd == WD_LAST) begin
                    err_timeout <= 1'b1;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                GAP: if (gap_cnt == GAP_LAST) begin
                    sr_start <= 1'b1;
                    state    <= START2;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_write_verify_ctrl.sv
// tb_sr_write_verify_ctrl: self-checking bench for sr_write_verify_ctrl with a behavioural shift-register model
module tb_sr_write_verify_ctrl;
    localparam int W   = 8;
    localparam int RW  = 2;
    localparam int TW  = 5;
    localparam int TWT = 4;
    localparam int G   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    sr_write_verify_ctrl_if #(.WIDTH(W), .RETRY_WIDTH(RW)) cif ();
    sr_write_verify_ctrl_if #(.WIDTH(W), .RETRY_WIDTH(RW)) tif ();

    logic          sr_start, done, ok, err_mismatch, err_timeout, busy;
    logic [W-1:0]  sr_din, prev_data;
    logic [RW-1:0] retries;
    logic          sr_valid = 1'b0;
    logic [W-1:0]  sr_dout  = '0;

    logic          t_sr_start, t_done, t_ok, t_err_mismatch, t_err_timeout, t_busy;
    logic [W-1:0]  t_sr_din, t_prev_data;
    logic [RW-1:0] t_retries;

    sr_write_verify_ctrl #(.WIDTH(W), .RETRY_WIDTH(RW), .TIMEOUT_WIDTH(TW), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .cmd(cif), .sr_start(sr_start), .sr_din(sr_din),
        .sr_valid(sr_valid), .sr_dout(sr_dout), .prev_data(prev_data), .done(done), .ok(ok),
        .err_mismatch(err_mismatch), .err_timeout(err_timeout), .retries(retries), .busy(busy)
    );

    // Second instance with a short watchdog and a datapath that never answers.
    sr_write_verify_ctrl #(.WIDTH(W), .RETRY_WIDTH(RW), .TIMEOUT_WIDTH(TWT), .GAP_CYCLES(G)) dut_to (
        .clk(clk), .rst(rst), .cmd(tif), .sr_start(t_sr_start), .sr_din(t_sr_din),
        .sr_valid(1'b0), .sr_dout({W{1'b0}}), .prev_data(t_prev_data), .done(t_done), .ok(t_ok),
        .err_mismatch(t_err_mismatch), .err_timeout(t_err_timeout), .retries(t_retries), .busy(t_busy)
    );

    // Behavioural shift register: a start shifts the new word in and the old
    // contents out; the old contents come back lat cycles later. Writes are
    // corrupted (bit 0 flipped) while corrupt_left is positive.
    logic [W-1:0] sr_reg = '0;
    logic [W-1:0] rb     = '0;
    int  lat          = 20;
    int  corrupt_left = 0;
    int  due          = 0;
    bit  pend         = 0;
    int  start_cyc[$];
    int  done_cnt     = 0;
    int  done_cyc     = 0;
    int  t_start_cyc[$];
    int  t_done_cnt   = 0;
    int  t_done_cyc   = 0;
    int  acc_cyc      = 0;

    always @(negedge clk) begin
        sr_valid = 1'b0;
        if (!rst) pend = 0;
        else begin
            if (pend && cyc == due) begin
                sr_valid = 1'b1;
                sr_dout  = rb;
                pend     = 0;
            end
            if (sr_start) begin
                start_cyc.push_back(cyc);
                rb     = sr_reg;
                sr_reg = corrupt_left > 0 ? sr_din ^ W'(1) : sr_din;
                if (corrupt_left > 0) corrupt_left--;
                due  = cyc + lat;
                pend = 1;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (t_sr_start) t_start_cyc.push_back(cyc);
        if (t_done) begin
            t_done_cnt++;
            t_done_cyc = cyc;
        end
    end

    // Expected outcome from the shift-register rules: each pass reads back what
    // the previous pass left behind; pass 1 returns the original contents.
    function automatic void predict(input logic [W-1:0] init, input logic [W-1:0] word, input int corrupt,
                                     input int mr, output logic [W-1:0] prev, output bit e_ok,
                                     output int e_r, output int e_passes);
        logic [W-1:0] held, back;
        int c = corrupt;
        prev     = init;
        held     = c > 0 ? word ^ W'(1) : word;
        c--;
        e_passes = 1;
        e_r      = 0;
        e_ok     = 0;
        while (1) begin
            back = held;
            held = c > 0 ? word ^ W'(1) : word;
            c--;
            e_passes++;
            if (back == word) begin
                e_ok = 1;
                return;
            end
            if (e_r == mr) return;
            e_r++;
        end
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [W-1:0] word, input logic [RW-1:0] mr);
        int b = 0;
        int d0 = done_cnt;
        start_cyc.delete();
        while (cif.cmd_ready !== 1'b1 && b < 200) begin
            step();
            b++;
        end
        cif.cmd_valid = 1'b1;
        cif.cmd_data  = word;
        cif.max_retry = mr;
        acc_cyc       = cyc;
        step();
        cif.cmd_valid = 1'b0;
        b = 0;
        while (done_cnt == d0 && b < 2000) begin
            step();
            b++;
        end
        n_tests++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL done_wait: no done after %0d cycles, want one", b);
        end
        step(8);
        n_tests++;
        if (done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL done_count: got %0d done pulses, want 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(3);
        n_tests++;
        if (cif.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: cmd_ready=%b busy=%b, want 1/0", cif.cmd_ready, busy);
        end
        n_tests++;
        if ({sr_start, done, ok, err_mismatch, err_timeout} !== 5'b0 || retries !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: start/done/ok/em/et=%b retries=%0d, want 0", {sr_start, done, ok, err_mismatch, err_timeout}, retries);
        end
        n_tests++;
        if (sr_din !== '0 || prev_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: sr_din=%h prev_data=%h, want 00/00", sr_din, prev_data);
        end
        @(negedge clk);
        rst = 1'b1;
        step(2);
        n_tests++;
        if (cif.cmd_ready !== 1'b1 || busy !== 1'b0 || sr_start !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: ready=%b busy=%b start=%b done=%b, want 1/0/0/0", cif.cmd_ready, busy, sr_start, done);
        end
    endtask

    task automatic test_basic();
        sr_reg = 8'h3C;
        lat = 20;
        corrupt_left = 0;
        do_cmd(8'hA5, 2'd0);
        n_tests++;
        if (prev_data !== 8'h3C || ok !== 1'b1 || retries !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_status: prev=%h ok=%b retries=%0d, want 3c/1/0", prev_data, ok, retries);
        end
        n_tests++;
        if (err_mismatch !== 1'b0 || err_timeout !== 1'b0 || sr_din !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_err: em=%b et=%b sr_din=%h, want 0/0/a5", err_mismatch, err_timeout, sr_din);
        end
        n_tests++;
        if (start_cyc.size() != 2 || start_cyc[0] != acc_cyc + 1 || start_cyc[1] != acc_cyc + 26) begin
            n_fail++;
            $display("FAIL basic_starts: %0d starts at offsets %p from accept %0d, want 2 at +1/+26", start_cyc.size(), start_cyc, acc_cyc);
        end
        n_tests++;
        if (done_cyc != acc_cyc + 47) begin
            n_fail++;
            $display("FAIL basic_done_time: done at +%0d after accept, want +47", done_cyc - acc_cyc);
        end
    endtask

    task automatic test_retry();
        sr_reg = 8'h00;
        lat = 20;
        corrupt_left = 2;
        do_cmd(8'h96, 2'd3);
        n_tests++;
        if (ok !== 1'b1 || err_mismatch !== 1'b0 || retries !== 2'd2) begin
            n_fail++;
            $display("FAIL retry_status: ok=%b em=%b retries=%0d, want 1/0/2", ok, err_mismatch, retries);
        end
        n_tests++;
        if (start_cyc.size() != 4) begin
            n_fail++;
            $display("FAIL retry_starts: got %0d sr_start pulses, want 4", start_cyc.size());
        end
    endtask

    task automatic test_mismatch();
        sr_reg = 8'hFF;
        lat = 10;
        corrupt_left = 1000;
        do_cmd(8'h4B, 2'd1);
        n_tests++;
        if (ok !== 1'b0 || err_mismatch !== 1'b1 || err_timeout !== 1'b0 || retries !== 2'd1) begin
            n_fail++;
            $display("FAIL mismatch_status: ok=%b em=%b et=%b retries=%0d, want 0/1/0/1", ok, err_mismatch, err_timeout, retries);
        end
        n_tests++;
        if (start_cyc.size() != 3 || prev_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL mismatch_starts: %0d starts prev=%h, want 3/ff", start_cyc.size(), prev_data);
        end
        corrupt_left = 0;
    endtask

    task automatic test_timeout();
        int b = 0;
        int d0 = t_done_cnt;
        t_start_cyc.delete();
        tif.cmd_valid = 1'b1;
        tif.cmd_data  = 8'h77;
        tif.max_retry = 2'd1;
        step();
        tif.cmd_valid = 1'b0;
        while (t_done_cnt == d0 && b < 200) begin
            step();
            b++;
        end
        step(8);
        n_tests++;
        if (t_done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL timeout_done: got %0d done pulses, want 1", t_done_cnt - d0);
        end
        n_tests++;
        if (t_err_timeout !== 1'b1 || t_ok !== 1'b0 || t_err_mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flags: et=%b ok=%b em=%b, want 1/0/0", t_err_timeout, t_ok, t_err_mismatch);
        end
        n_tests++;
        if (t_start_cyc.size() != 1 || t_done_cyc - t_start_cyc[0] != 16) begin
            n_fail++;
            $display("FAIL timeout_time: %0d starts, done-start=%0d, want 1/16", t_start_cyc.size(), t_done_cyc - (t_start_cyc.size() > 0 ? t_start_cyc[0] : 0));
        end
    endtask

    task automatic test_coincident();
        sr_reg = 8'h11;
        lat = 31;
        corrupt_left = 0;
        do_cmd(8'hE7, 2'd0);
        n_tests++;
        if (ok !== 1'b1 || err_timeout !== 1'b0 || prev_data !== 8'h11) begin
            n_fail++;
            $display("FAIL coincident_status: ok=%b et=%b prev=%h, want 1/0/11", ok, err_timeout, prev_data);
        end
        n_tests++;
        if (start_cyc.size() != 2 || done_cyc != start_cyc[start_cyc.size()-1] + 32) begin
            n_fail++;
            $display("FAIL coincident_time: %0d starts, done at %0d, want 2 starts and done 32 after last", start_cyc.size(), done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int b = 0;
        int d0;
        sr_reg = 8'h00;
        lat = 20;
        corrupt_left = 0;
        start_cyc.delete();
        cif.cmd_valid = 1'b1;
        cif.cmd_data  = 8'hC3;
        cif.max_retry = 2'd0;
        step();
        cif.cmd_valid = 1'b0;
        while (start_cyc.size() < 2 && b < 200) begin
            step();
            b++;
        end
        n_tests++;
        if (start_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL mid_reach_wait2: got %0d starts, want 2", start_cyc.size());
        end
        step(5);
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({sr_start, done, ok, err_mismatch, err_timeout, busy} !== 6'b0 || retries !== '0 || cif.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_flags: start/done/ok/em/et/busy=%b retries=%0d ready=%b, want 0/0/1", {sr_start, done, ok, err_mismatch, err_timeout, busy}, retries, cif.cmd_ready);
        end
        n_tests++;
        if (sr_din !== '0 || prev_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_data: sr_din=%h prev=%h, want 00/00", sr_din, prev_data);
        end
        step(30);
        @(negedge clk);
        rst = 1'b1;
        step(3);
        n_tests++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL mid_no_done: got %0d done pulses after abort, want 0", done_cnt - d0);
        end
        do_cmd(8'h5A, 2'd0);
        n_tests++;
        if (ok !== 1'b1 || prev_data !== 8'hC3 || sr_din !== 8'h5A) begin
            n_fail++;
            $display("FAIL mid_recover: ok=%b prev=%h sr_din=%h, want 1/c3/5a", ok, prev_data, sr_din);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] init, word, e_prev;
        bit e_ok;
        int e_r, e_passes, mr, cor, bad;
        for (int k = 0; k < 8; k++) begin
            init = W'($urandom);
            word = W'($urandom);
            mr   = int'($urandom_range(0, 3));
            cor  = int'($urandom_range(0, 4));
            lat  = int'($urandom_range(1, 30));
            sr_reg = init;
            corrupt_left = cor;
            predict(init, word, cor, mr, e_prev, e_ok, e_r, e_passes);
            do_cmd(word, RW'(mr));
            n_tests++;
            if (prev_data !== e_prev || ok !== e_ok || err_mismatch !== !e_ok || err_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_status: prev=%h ok=%b em=%b et=%b, want %h/%b/%b/0", k, prev_data, ok, err_mismatch, err_timeout, e_prev, e_ok, !e_ok);
            end
            n_tests++;
            if (retries !== RW'(e_r) || start_cyc.size() != e_passes) begin
                n_fail++;
                $display("FAIL rand%0d_passes: retries=%0d starts=%0d, want %0d/%0d", k, retries, start_cyc.size(), e_r, e_passes);
            end
            bad = (start_cyc.size() == 0 || start_cyc[0] != acc_cyc + 1) ? 1 : 0;
            for (int i = 1; i < start_cyc.size(); i++)
                if (start_cyc[i] - start_cyc[i-1] != lat + 1 + G) bad++;
            if (start_cyc.size() > 0 && done_cyc != start_cyc[start_cyc.size()-1] + lat + 1) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rand%0d_timing: accept=%0d starts=%p done=%0d lat=%0d, want start at accept+1, spacing %0d, done lat+1 after last", k, acc_cyc, start_cyc, done_cyc, lat, lat + 1 + G);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "global timeout");
    end

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_data  = '0;
        cif.max_retry = '0;
        tif.cmd_valid = 1'b0;
        tif.cmd_data  = '0;
        tif.max_retry = '0;
        test_reset();
        test_basic();
        test_retry();
        test_mismatch();
        test_timeout();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
